// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8: round-robin owner selection for an 8-way one-hot select
// resource. The grant address and its one-hot decode are both registered.
// A grant is held until the owner raises done or drops its request. Every
// grant is followed by at least one IDLE cycle, so ownership never switches
// directly from one requester to another.
// Optional build macro: ARB_TIMEOUT_EN forces a release after MAX_HOLD grant
// cycles and reports it with a one-cycle timeout pulse.
module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic       grant_valid_o,
    output logic [2:0] grant_addr_o,
    output logic [7:0] grant_o,
    output logic       timeout_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] last_q,  last_d;
    logic [2:0] addr_q,  addr_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] winner;
    logic       owner_rel;
    logic       force_rel;

    // Search order starts just after the last owner and wraps modulo 8.
    // The 3-bit sum wraps naturally, and k=8 comes back to last_q itself.
    always_comb begin
        winner = last_q;
        for (int k = 8; k >= 1; k--) begin
            if (req_i[last_q + 3'(k)]) winner = last_q + 3'(k);
        end
    end

    // Only the owner's request bit and done matter while a grant is held.
    assign owner_rel = done_i | ~req_i[addr_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    // A forced release happens only when the owner has not released on its
    // own. If done coincides with the limit, the release counts as normal.
    assign force_rel = (state_q == ST_GRANT) && !owner_rel &&
                       (hold_q == 8'(MAX_HOLD - 1));

    // Hold counter: counts GRANT cycles and clears on any release and in IDLE.
    always_comb begin
        hold_d    = 8'd0;
        timeout_d = 1'b0;
        if (state_q == ST_GRANT) begin
            if (force_rel)      timeout_d = 1'b1;
            else if (!owner_rel) hold_d   = hold_q + 8'd1;
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_max_hold;

    assign force_rel       = 1'b0;
    assign timeout_o       = 1'b0;
    assign unused_max_hold = (MAX_HOLD != 0);
`endif

    // Next-state logic: IDLE picks a winner, GRANT waits for a release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_GRANT;
                    addr_d  = winner;
                    grant_d = 8'd1 << winner;
                end
            end
            ST_GRANT: begin
                if (owner_rel || force_rel) begin
                    state_d = ST_IDLE;
                    last_d  = addr_q;
                    grant_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'd0;
            end
        endcase
    end

    // State registers. After reset, last=7 so the first search starts at 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            last_q  <= 3'd7;
            addr_q  <= 3'd0;
            grant_q <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
        end
    end

    assign grant_valid_o = (state_q == ST_GRANT);
    assign grant_addr_o  = addr_q;
    assign grant_o       = grant_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb_rr_grant_arbiter8: directed scenarios followed by random stimulus.
// Every edge is checked against a reference model that tracks the owner and
// the last served index as integers. Builds with or without ARB_TIMEOUT_EN.
module tb_rr_grant_arbiter8;

`ifdef ARB_TIMEOUT_EN
    localparam int MH    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MH    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_addr;
    logic [7:0] grant;
    logic       timeout;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model state
    int m_owner;   // -1 while idle
    int m_last;
    int m_addr;
    int m_hold;
    bit m_to;

    rr_grant_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_i        (req),
        .done_i       (done),
        .grant_valid_o(grant_valid),
        .grant_addr_o (grant_addr),
        .grant_o      (grant),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_addr  = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    // One clock edge of the arbiter rules, given the inputs sampled there.
    task automatic model_step(input logic [7:0] r, input logic d);
        bit rel;
        bit frc;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
                if (m_owner < 0 && r[(m_last + k) % 8]) begin
                    m_owner = (m_last + k) % 8;
                    m_addr  = m_owner;
                    m_hold  = 0;
                end
            end
        end else begin
            rel = d || !r[m_owner];
            frc = TO_EN && !rel && (m_hold == MH - 1);
            if (rel || frc) begin
                m_last  = m_owner;
                m_owner = -1;
                m_hold  = 0;
                m_to    = frc;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] eg;
        eg = 8'd0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant_valid", grant_valid, (m_owner >= 0));
        chk("grant_addr",  grant_addr,  m_addr);
        chk("grant",       grant,       eg);
        chk("timeout",     timeout,     m_to);
        chk("onehot0",     $onehot0(grant), 1);
    endtask

    // Apply the current inputs across one rising edge and check afterwards.
    task automatic tick();
        logic [7:0] r;
        logic       d;
        r = req;
        d = done;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int seq [$];
        bit prev_v;
        int to_cnt;

        reset_n = 1'b0;
        req     = 8'd0;
        done    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Single requester 2, released by done
        req = 8'b0000_0100;
        tick();
        chk("t1_addr",  grant_addr, 3'd2);
        chk("t1_grant", grant,      8'b0000_0100);
        done = 1'b1;
        tick();
        chk("t1_rel", grant, 8'd0);
        done = 1'b0;
        req  = 8'd0;
        tick();

        // All requesting, done held: 0..7 then 0, idle cycle between grants
        do_reset();
        req    = 8'hFF;
        done   = 1'b1;
        prev_v = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("turnaround", prev_v & grant_valid, 1'b0);
            if (grant_valid) seq.push_back(int'(grant_addr));
            prev_v = grant_valid;
        end
        chk("rr_count", seq.size(), 9);
        for (int i = 0; i < seq.size(); i++) chk("rr_seq", seq[i], i % 8);
        done = 1'b0;
        req  = 8'd0;
        tick();

        // Owner 5 drops its request; next search wraps past 7 to 0
        do_reset();
        req = 8'b0010_0000;
        tick();
        chk("t3_own5", grant_addr, 3'd5);
        req = 8'd0;
        tick();
        chk("t3_drop", grant_valid, 1'b0);
        req = 8'b0010_0001;
        tick();
        chk("t3_wrap", grant_addr, 3'd0);
        req = 8'd0;
        tick();

        // Requests from others are ignored while owner 1 holds
        do_reset();
        req = 8'b0000_0010;
        tick();
        req = 8'b0100_1010;
        repeat (3) begin
            tick();
            chk("t4_hold", grant_addr, 3'd1);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t4_next3", grant_addr, 3'd3);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t4_next6", grant_addr, 3'd6);
        req = 8'd0;
        tick();

        // Asynchronous reset while a grant is held
        req = 8'b0000_0010;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", grant_valid, 1'b0);
        chk("ar_grant", grant,       8'd0);
        chk("ar_addr",  grant_addr,  3'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        req = 8'b1000_0001;
        tick();
        chk("ar_first", grant_addr, 3'd0);
        req = 8'd0;
        tick();

        // Long hold with done low
        do_reset();
        req    = 8'b0000_0010;
        to_cnt = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 5) begin
                chk("lh_pulse", timeout, TO_EN);
                chk("lh_grant", grant,   TO_EN ? 8'd0 : 8'b0000_0010);
            end
            if (i == 6) chk("lh_regrant", grant, 8'b0000_0010);
            if (timeout) to_cnt++;
        end
        chk("lh_any_to", (to_cnt != 0), TO_EN);
        req = 8'd0;
        tick();

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req  = 8'($urandom) & 8'($urandom);
            done = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way one-hot select resource (3-bit address decoded to an 8-bit one-hot bus) between 8 requesters.
- Samples a request vector and picks the next requester after the last one served.
- Drives a registered 3-bit grant address plus its one-hot decode.
- Holds the grant until the owner signals done or drops its request.

Parameters:
MAX_HOLD, 16, maximum grant length in cycles before forced release; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  8  request vector; bit i = requester i wants the resource.
done  input  1  owner finished; sampled only while grant_valid=1.
grant_valid  output  1  a grant is active this cycle.
grant_addr  output  3  index of the current owner.
grant  output  8  one-hot decode of grant_addr; all zeros when grant_valid=0.
timeout  output  1  one-cycle pulse on a forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values, asserted immediately on reset_n low regardless of clk:
  - state=IDLE, grant_valid=0, grant_addr=0, grant=8'b0, timeout=0.
  - last pointer=7, so the first search starts at index 0.
  - hold counter=0.
- Reset mid-grant drops the grant at once. No done handshake is required.
- States:
  - IDLE: if req==0, stay. Otherwise search indices (last+1) mod 8, (last+2) mod 8, ..., last in order; the first set bit wins. On the next edge, load grant_addr=winner, set grant_valid=1, go to GRANT.
  - GRANT: release when done=1 or req[grant_addr]=0 is sampled at an edge. On that edge: grant_valid=0, grant=0, last=grant_addr, counter cleared, go to IDLE.
- Latency: request seen at edge k gives grant visible after edge k (registered, 1 cycle).
- Turnaround: at least one IDLE cycle between consecutive grants, so the resource never switches owner in the same cycle.
- Requests from non-owners during GRANT are ignored. Only the owner's req bit and done affect GRANT.
- done while in IDLE is ignored.
- Wrap-around: search order is modulo 8. After serving 7, index 0 has highest priority.
- A lone requester may be re-granted after its own turnaround cycle.
- grant must equal 1<<grant_addr when grant_valid=1 and 8'b0 otherwise. There is never more than one bit set and never X.
- grant_addr holds its last value while IDLE. It is don't-care for consumers.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter increments every GRANT cycle.
  - If it reaches MAX_HOLD-1 with no release condition, the next edge forces release as a normal release: last updated, IDLE entered, timeout=1 for exactly one cycle.
  - If done and the timeout limit coincide, the release is normal and timeout stays 0.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout is constant 0.
  - A grant lasts indefinitely until done or the owner's req drops.

Test Plan:
- Reset, then req=8'b0000_0100 -> after 1 edge: grant_valid=1, grant_addr=2, grant=8'b0000_0100. Pulse done -> grant=0 next cycle.
- req=8'hFF held, done pulsed on every grant cycle -> grant_addr sequence 0,1,2,...,7,0 with one idle cycle between each grant. Never two grant bits set.
- Owner 5 granted, then req[5] dropped with done=0 -> grant released next edge. With req=8'b0010_0001, the next grant goes to 0 (wrap past 7).
- req[3] and req[6] asserted during owner 1's grant -> grant stays at 1 until done. Then 3, then 6.
- Assert reset_n=0 mid-grant between clock edges -> grant, grant_valid and grant_addr go to 0 immediately. After release with req=8'b1000_0001, the first grant goes to 0.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'b0000_0010 held and done=0 -> grant active for 4 cycles, then a one-cycle timeout pulse with grant=0, then re-granted to 1 after one idle cycle. Without the macro -> grant held for 100+ cycles and timeout stays 0.
